// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - triggered sensor-trace capture into RAM with byte-stream dump
module trace_capture #(
  parameter int SAMPLE_W   = 7,
  parameter int WORD_BYTES = 2,
  parameter int DEPTH      = 512,
  parameter int ADDR_W     = 9,
  parameter int DEC_W      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig,
  input  logic [15:0]         delay,
  input  logic [ADDR_W:0]     count,
  input  logic [DEC_W-1:0]    decim,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state_o
);

  localparam int SW = 8 * WORD_BYTES;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      LAST_B  = 8'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_CAPTURE = 3'd3,
    S_DUMP    = 3'd4
  } state_t;

  state_t            state;
  logic              trig_q;
  logic [15:0]       delay_r;
  logic [DEC_W-1:0]  decim_r;
  logic [ADDR_W:0]   cnt_r;
  logic [15:0]       dcnt;
  logic [DEC_W-1:0]  sub;
  logic [SW-1:0]     acc;
  logic [ADDR_W:0]   waddr;
  logic [ADDR_W:0]   raddr;
  logic [7:0]        bidx;
  logic              pend;
  logic [SW-1:0]     shreg;
  logic [SW-1:0]     rd_data;
  logic [SW-1:0]     mem [DEPTH];

  logic [SW:0]       sum_ext;
  logic [SW-1:0]     acc_next;
  logic              wr_en;

  assign sum_ext  = {1'b0, acc} + {{(SW + 1 - SAMPLE_W){1'b0}}, sample};
  assign acc_next = sum_ext[SW] ? {SW{1'b1}} : sum_ext[SW-1:0];
  assign wr_en    = (state == S_CAPTURE) && sample_valid && (sub == decim_r);

  assign tx_data = shreg[7:0];
  assign busy    = (state != S_IDLE);
  assign state_o = state;

  // Plain synchronous RAM: write port from the accumulator, registered read port for the dump.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr[ADDR_W-1:0]] <= acc_next;
    rd_data <= mem[raddr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      trig_q   <= 1'b0;
      delay_r  <= '0;
      decim_r  <= '0;
      cnt_r    <= '0;
      dcnt     <= '0;
      sub      <= '0;
      acc      <= '0;
      waddr    <= '0;
      raddr    <= '0;
      bidx     <= '0;
      pend     <= 1'b0;
      shreg    <= '0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      trig_q <= trig;
      done   <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state    <= S_IDLE;
        tx_valid <= 1'b0;
        dcnt     <= '0;
        sub      <= '0;
        acc      <= '0;
        waddr    <= '0;
        raddr    <= '0;
        bidx     <= '0;
        pend     <= 1'b0;
        done     <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm) begin
              delay_r <= delay;
              decim_r <= decim;
              cnt_r   <= (count > DEPTH_C) ? DEPTH_C : count;
              if (count == '0) done  <= 1'b1;
              else             state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (trig && !trig_q) state <= (delay_r != '0) ? S_DELAY : S_CAPTURE;
          end
          S_DELAY: begin
            if (sample_valid) begin
              if (dcnt + 16'd1 == delay_r) begin
                dcnt  <= '0;
                state <= S_CAPTURE;
              end else begin
                dcnt <= dcnt + 16'd1;
              end
            end
          end
          S_CAPTURE: begin
            if (sample_valid) begin
              if (sub == decim_r) begin
                acc   <= '0;
                sub   <= '0;
                waddr <= waddr + 1'b1;
                if (waddr + 1'b1 == cnt_r) begin
                  state <= S_DUMP;
                  raddr <= '0;
                  pend  <= 1'b1;
                  bidx  <= '0;
                end
              end else begin
                acc <= acc_next;
                sub <= sub + 1'b1;
              end
            end
          end
          S_DUMP: begin
            // raddr runs one word ahead of shreg, so each next word is already in rd_data
            // by the bubble cycle that follows the last byte of the current word.
            if (!tx_valid) begin
              if (pend) begin
                pend <= 1'b0;
              end else begin
                shreg    <= rd_data;
                tx_valid <= 1'b1;
                raddr    <= raddr + 1'b1;
                bidx     <= '0;
              end
            end else if (tx_ready) begin
              if (bidx == LAST_B) begin
                tx_valid <= 1'b0;
                if (raddr == cnt_r) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                  raddr <= '0;
                  waddr <= '0;
                end
              end else begin
                shreg <= shreg >> 8;
                bidx  <= bidx + 8'd1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - scoreboard bench for trace_capture (2-byte and 1-byte word instances)
module tb_trace_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0, abort = 1'b0, trig = 1'b0, sample_valid = 1'b0, tx_ready = 1'b0;
  logic [15:0] delay = '0;
  logic [9:0]  count = '0;
  logic [3:0]  decim = '0;
  logic [6:0]  sample = '0;

  logic [7:0] txd0, txd1;
  logic       txv0, txv1, busy0, busy1, done0, done1;
  logic [2:0] st0, st1;

  trace_capture #(.WORD_BYTES(2)) u_w2 (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig), .delay(delay),
    .count(count), .decim(decim), .sample(sample), .sample_valid(sample_valid),
    .tx_data(txd0), .tx_valid(txv0), .tx_ready(tx_ready), .busy(busy0), .done(done0),
    .state_o(st0));

  trace_capture #(.WORD_BYTES(1)) u_w1 (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig), .delay(delay),
    .count(count), .decim(decim), .sample(sample), .sample_valid(sample_valid),
    .tx_data(txd1), .tx_valid(txv1), .tx_ready(tx_ready), .busy(busy1), .done(done1),
    .state_o(st1));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int ready_mode = 0;
  logic [7:0] q0[$], q1[$];
  int samp[$];
  int acc0 = 0, acc1 = 0;
  bit seen0 = 0, seen1 = 0;
  logic pv0 = 0, pv1 = 0, pr = 0, pa = 0;
  logic [7:0] pd0 = 0, pd1 = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every accepted byte and checks hold-under-backpressure.
  always @(negedge clk) begin
    if (!rst) begin
      if (pv0 && !pr && !pa) begin chk("hold_valid0", txv0, 1); chk("hold_data0", txd0, pd0); end
      if (pv1 && !pr && !pa) begin chk("hold_valid1", txv1, 1); chk("hold_data1", txd1, pd1); end
      if (txv0 && tx_ready && !abort) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_byte0: got 0x%0h expected no byte", txd0);
        end else chk("byte0", txd0, q0.pop_front());
        acc0++;
      end
      if (txv1 && tx_ready && !abort) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL extra_byte1: got 0x%0h expected no byte", txd1);
        end else chk("byte1", txd1, q1.pop_front());
        acc1++;
      end
      if (done0) seen0 = 1;
      if (done1) seen1 = 1;
    end
    pv0 = txv0; pv1 = txv1; pd0 = txd0; pd1 = txd1; pr = tx_ready; pa = abort;
  end

  task automatic cyc(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic arm_cfg(int dl, int dc, int cn);
    delay = 16'(dl); decim = 4'(dc); count = 10'(cn); arm = 1; seen0 = 0; seen1 = 0;
    cyc();
    arm = 0; delay = 16'($urandom); decim = 4'($urandom); count = 10'($urandom);
  endtask

  // Reference: skip dl samples, sum groups of dc+1, clamp to the word range, keep min(cn,512) words.
  task automatic model(int dl, int dc, int cn);
    int n;
    int s;
    int s16;
    int s8;
    n = (cn > 512) ? 512 : cn;
    for (int w = 0; w < n; w++) begin
      s = 0;
      for (int j = 0; j <= dc; j++) s += samp[dl + w * (dc + 1) + j];
      s16 = (s > 65535) ? 65535 : s;
      s8  = (s > 255) ? 255 : s;
      q0.push_back(8'(s16)); q0.push_back(8'(s16 >> 8)); q1.push_back(8'(s8));
    end
  endtask

  task automatic trig_feed(bit toggle);
    trig = 0; sample_valid = 1; sample = 7'($urandom); cyc();
    trig = 1; sample_valid = 1; sample = 7'($urandom); cyc();
    foreach (samp[i]) begin
      sample_valid = 0; sample = 7'($urandom); cyc($urandom_range(0, 2));
      sample = 7'(samp[i]); sample_valid = 1;
      if (toggle) trig = 1'($urandom);
      cyc();
    end
    sample_valid = 0; trig = 0;
  endtask

  task automatic wait_both(string name, int budget);
    int n;
    n = 0;
    while (!(seen0 && seen1) && n < budget) begin @(negedge clk); n++; end
    if (!(seen0 && seen1)) begin
      tests++; fails++;
      $display("FAIL %s_finish: got no done within %0d cycles, expected done", name, budget);
    end else begin
      chk({name, "_left0"}, q0.size(), 0);
      chk({name, "_left1"}, q1.size(), 0);
      chk({name, "_busy0"}, busy0, 0);
      chk({name, "_busy1"}, busy1, 0);
      chk({name, "_state0"}, st0, 0);
    end
  endtask

  task automatic rand_samps(int n);
    samp.delete();
    repeat (n) samp.push_back($urandom_range(0, 127));
  endtask

  initial begin
    int a0, a1, n, dl, dc, cn;
    logic [7:0] held;
    repeat (3) @(negedge clk);
    chk("rst_txd0", txd0, 0); chk("rst_txv0", txv0, 0); chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0); chk("rst_state0", st0, 0); chk("rst_txv1", txv1, 0);
    cyc(); rst = 0; cyc(2);

    // Basic capture, immediate acceptance.
    ready_mode = 0;
    samp = '{5, 9, 127};
    model(0, 0, 3);
    arm_cfg(0, 0, 3);
    chk("t1_armed", st0, 1);
    trig_feed(0);
    wait_both("t1", 2000);

    // Delay and decimation.
    samp = '{1, 2, 3, 4, 10, 20};
    model(2, 1, 2);
    arm_cfg(2, 1, 2);
    trig_feed(1);
    wait_both("t2", 2000);

    // Saturation on the 1-byte instance.
    samp.delete();
    repeat (32) samp.push_back(127);
    ready_mode = 1;
    model(0, 15, 2);
    arm_cfg(0, 15, 2);
    trig_feed(1);
    wait_both("t3", 2000);

    // Backpressure followed by random ready.
    for (int r = 0; r < 3; r++) begin
      dl = $urandom_range(0, 5); dc = $urandom_range(0, 3); cn = $urandom_range(4, 8);
      rand_samps(dl + cn * (dc + 1));
      ready_mode = 2;
      model(dl, dc, cn);
      arm_cfg(dl, dc, cn);
      trig_feed(1);
      n = 0;
      while (!txv0 && n < 200) begin @(negedge clk); n++; end
      chk("t4_valid_up", txv0, 1);
      held = txd0;
      repeat (10) begin
        @(negedge clk);
        chk("t4_bp_valid", txv0, 1);
        chk("t4_bp_data", txd0, held);
      end
      ready_mode = 1;
      wait_both("t4", 3000);
    end

    // Trigger already high at arm, then oversized count.
    ready_mode = 0;
    trig = 1; cyc(2);
    rand_samps(1 + 512);
    model(1, 0, 600);
    a0 = acc0; a1 = acc1;
    arm_cfg(1, 0, 600);
    trig = 1; sample_valid = 1; cyc(4); sample_valid = 0;
    chk("t5_still_armed", st0, 1);
    trig_feed(0);
    wait_both("t5", 20000);
    chk("t5_bytes0", acc0 - a0, 1024);
    chk("t5_bytes1", acc1 - a1, 512);

    // count=0 arm.
    arm_cfg(0, 0, 0);
    @(negedge clk);
    chk("t6_zero_done0", done0, 1); chk("t6_zero_done1", done1, 1); chk("t6_zero_state", st0, 0);
    cyc(3);

    // Arm while ARMED is ignored.
    rand_samps(3);
    arm_cfg(0, 0, 3);
    cyc(2);
    arm_cfg(0, 0, 7);
    chk("t6_rearm_state", st0, 1);
    model(0, 0, 3);
    trig_feed(1);
    wait_both("t6_rearm", 2000);

    // Abort during CAPTURE.
    rand_samps(3);
    arm_cfg(0, 0, 10);
    trig_feed(0);
    @(negedge clk);
    chk("t6_in_capture", st0, 3);
    cyc(); abort = 1; cyc(); abort = 0;
    @(negedge clk);
    chk("t6_abc_state0", st0, 0); chk("t6_abc_state1", st1, 0);
    chk("t6_abc_done0", done0, 1); chk("t6_abc_done1", done1, 1);
    chk("t6_abc_busy0", busy0, 0); chk("t6_abc_txv0", txv0, 0);
    @(negedge clk);
    chk("t6_abc_pulse", done0, 0);
    cyc(); abort = 1; cyc(); abort = 0;
    @(negedge clk);
    chk("t6_idle_abort_done", done0, 0);

    // Abort mid-DUMP.
    rand_samps(8);
    model(0, 0, 8);
    a0 = acc0;
    arm_cfg(0, 0, 8);
    trig_feed(0);
    n = 0;
    while (acc0 < a0 + 3 && n < 500) begin @(negedge clk); n++; end
    chk("t6_dump_started", (acc0 >= a0 + 3) ? 1 : 0, 1);
    cyc(); abort = 1; cyc(); abort = 0;
    @(negedge clk);
    chk("t6_abd_state0", st0, 0); chk("t6_abd_state1", st1, 0);
    chk("t6_abd_txv0", txv0, 0); chk("t6_abd_txv1", txv1, 0);
    chk("t6_abd_done0", done0, 1); chk("t6_abd_done1", done1, 1);
    q0.delete(); q1.delete();
    cyc(5);

    // Recovery after abort.
    ready_mode = 1;
    rand_samps(2 + 5 * 3);
    model(2, 2, 5);
    arm_cfg(2, 2, 5);
    trig_feed(1);
    wait_both("t7", 3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
